// File: rtl/nocr_input_arbiter.sv
// Round-robin arbiter sharing one NOC router packet port among NUM_REQ generators.
// One transaction is open at a time: accept in IDLE, hold the packet in SEND,
// then route the router response to the owner in WAIT.
module nocr_input_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PKT_W   = 13,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*PKT_W-1:0] req_packet,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [PKT_W-1:0]         packet,
  output logic                     pack_valid,
  input  logic                     nocr_ready,
  input  logic                     nocr_valid,
  output logic                     pack_gen_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PKT_W-1:0]   packet_q, packet_d;
  logic               pack_valid_q, pack_valid_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PKT_W-1:0]   pkt_sel;
  logic               owner_ack;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[PTR_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Select the winner's packet slice.
  always_comb begin
    pkt_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win_idx) pkt_sel = req_packet[i*PKT_W +: PKT_W];
    end
  end

  assign owner_ack = |(grant_q & resp_ready);

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    packet_d       = packet_q;
    pack_valid_d   = pack_valid_q;
    grant_d        = grant_q;
    busy_d         = busy_q;
    cnt_d          = cnt_q;
    req_ready      = '0;
    resp_valid     = '0;
    pack_gen_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready    = NUM_REQ'(1) << win_idx;
          packet_d     = pkt_sel;
          grant_d      = NUM_REQ'(1) << win_idx;
          owner_d      = win_idx;
          pack_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (pack_valid_q && nocr_ready) begin
          pack_valid_d = 1'b0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        resp_valid     = grant_q & {NUM_REQ{nocr_valid}};
        pack_gen_ready = owner_ack;
        if (nocr_valid && owner_ack) begin
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any open transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      packet_q     <= '0;
      pack_valid_q <= 1'b0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      packet_q     <= packet_d;
      pack_valid_q <= pack_valid_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign packet     = packet_q;
  assign pack_valid = pack_valid_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign txn_count  = cnt_q;

endmodule

// File: tb/tb_nocr_input_arbiter.sv
// Directed bench for nocr_input_arbiter: vector table plus multi-cycle sequences.
module tb_nocr_input_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PKT_W   = 13;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NVEC    = 20;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*PKT_W-1:0] req_packet;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [PKT_W-1:0]         packet;
  logic                     pack_valid;
  logic                     nocr_ready;
  logic                     nocr_valid;
  logic                     pack_gen_ready;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         txn_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  rv;
    logic        nr;
    logic        nv;
    logic [3:0]  rr;
    logic [3:0]  e_rq;
    logic        e_pv;
    logic [12:0] e_pkt;
    logic [3:0]  e_gnt;
    logic        e_busy;
    logic [3:0]  e_resp;
    logic        e_pgr;
    logic [15:0] e_txn;
  } vec_t;

  vec_t vec [NVEC];
  logic [PKT_W-1:0] pk [NUM_REQ];

  nocr_input_arbiter #(.NUM_REQ(NUM_REQ), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_packet(req_packet), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .packet(packet), .pack_valid(pack_valid), .nocr_ready(nocr_ready),
    .nocr_valid(nocr_valid), .pack_gen_ready(pack_gen_ready),
    .grant(grant), .busy(busy), .txn_count(txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] rv, input logic nr, input logic nv,
                              input logic [3:0] rr, input logic [3:0] rq, input logic pv,
                              input logic [12:0] pkt, input logic [3:0] gnt, input logic bsy,
                              input logic [3:0] rsp, input logic pgr, input logic [15:0] txn);
    vec_t v;
    v = '{rv: rv, nr: nr, nv: nv, rr: rr, e_rq: rq, e_pv: pv, e_pkt: pkt, e_gnt: gnt,
          e_busy: bsy, e_resp: rsp, e_pgr: pgr, e_txn: txn};
    return v;
  endfunction

  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    nocr_ready = 1'b0;
    nocr_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
  endtask

  // One full transaction for generator idx, starting in IDLE with its request visible.
  task automatic do_txn(input int idx);
    logic [3:0] oh;
    oh = 4'(1) << idx;
    #1;
    chk("txn_req_ready", 32'(req_ready), 32'(oh));
    step();
    chk("txn_grant", 32'(grant), 32'(oh));
    chk("txn_pack_valid", 32'(pack_valid), 32'd1);
    chk("txn_packet", 32'(packet), 32'(pk[idx]));
    nocr_ready = 1'b1;
    step();
    nocr_ready = 1'b0;
    nocr_valid = 1'b1;
    resp_ready = 4'hF;
    #1;
    chk("txn_resp_valid", 32'(resp_valid), 32'(oh));
    chk("txn_pgr", 32'(pack_gen_ready), 32'd1);
    step();
    nocr_valid = 1'b0;
    resp_ready = '0;
    chk("txn_done_grant", 32'(grant), 32'd0);
    chk("txn_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    pk[0] = 13'h0A5;
    pk[1] = 13'h101;
    pk[2] = 13'h102;
    pk[3] = 13'h103;
    for (int i = 0; i < int'(NUM_REQ); i++) req_packet[i*PKT_W +: PKT_W] = pk[i];

    //        rv    nr    nv    rr    | rq    pv    pkt      gnt   bsy   resp  pgr   txn
    vec[0]  = mk(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 13'h000, 4'h0, 1'b0, 4'h0, 1'b0, 16'd0);
    vec[1]  = mk(4'h1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 13'h000, 4'h0, 1'b0, 4'h0, 1'b0, 16'd0);
    vec[2]  = mk(4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 13'h0A5, 4'h1, 1'b1, 4'h0, 1'b0, 16'd0);
    vec[3]  = mk(4'h0, 1'b0, 1'b1, 4'h1, 4'h0, 1'b0, 13'h0A5, 4'h1, 1'b1, 4'h1, 1'b1, 16'd0);
    vec[4]  = mk(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 13'h0A5, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1);
    vec[5]  = mk(4'h0, 1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 13'h0A5, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1);
    vec[6]  = mk(4'h6, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0, 13'h0A5, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1);
    vec[7]  = mk(4'h6, 1'b0, 1'b1, 4'h2, 4'h0, 1'b1, 13'h101, 4'h2, 1'b1, 4'h0, 1'b0, 16'd1);
    vec[8]  = mk(4'h6, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 13'h101, 4'h2, 1'b1, 4'h0, 1'b0, 16'd1);
    vec[9]  = vec[8];
    vec[10] = vec[8];
    vec[11] = vec[8];
    vec[12] = mk(4'h6, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 13'h101, 4'h2, 1'b1, 4'h0, 1'b0, 16'd1);
    vec[13] = mk(4'h6, 1'b0, 1'b1, 4'hD, 4'h0, 1'b0, 13'h101, 4'h2, 1'b1, 4'h2, 1'b0, 16'd1);
    vec[14] = vec[13];
    vec[15] = vec[13];
    vec[16] = mk(4'h6, 1'b0, 1'b1, 4'h2, 4'h0, 1'b0, 13'h101, 4'h2, 1'b1, 4'h2, 1'b1, 16'd1);
    vec[17] = mk(4'h6, 1'b0, 1'b0, 4'h0, 4'h4, 1'b0, 13'h101, 4'h0, 1'b0, 4'h0, 1'b0, 16'd2);
    vec[18] = mk(4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 13'h102, 4'h4, 1'b1, 4'h0, 1'b0, 16'd2);
    vec[19] = mk(4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 1'b0, 13'h102, 4'h4, 1'b1, 4'h0, 1'b1, 16'd2);

    do_reset();

    // Table: single request, stray response, router and response backpressure.
    for (int i = 0; i < int'(NVEC); i++) begin
      req_valid  = vec[i].rv;
      nocr_ready = vec[i].nr;
      nocr_valid = vec[i].nv;
      resp_ready = vec[i].rr;
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vec[i].e_rq));
      chk($sformatf("v%0d_pack_valid", i), 32'(pack_valid), 32'(vec[i].e_pv));
      chk($sformatf("v%0d_packet", i), 32'(packet), 32'(vec[i].e_pkt));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vec[i].e_gnt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].e_busy));
      chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vec[i].e_resp));
      chk($sformatf("v%0d_pgr", i), 32'(pack_gen_ready), 32'(vec[i].e_pgr));
      chk($sformatf("v%0d_txn", i), 32'(txn_count), 32'(vec[i].e_txn));
      step();
    end

    // Reset mid-WAIT with grant=0100: outputs clear at once, pointer back to 0.
    chk("wait_grant_before_rst", 32'(grant), 32'h4);
    nocr_valid = 1'b1;
    resp_ready = 4'h4;
    reset      = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pack_valid", 32'(pack_valid), 32'd0);
    chk("rst_packet", 32'(packet), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_pgr", 32'(pack_gen_ready), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    nocr_valid = 1'b0;
    resp_ready = '0;
    req_valid  = 4'h6;
    step();
    reset = 1'b1;
    #1;
    chk("rst_ptr0_winner", 32'(req_ready), 32'h2);
    req_valid = 4'h4;
    do_txn(2);
    chk("rst_txn_after", 32'(txn_count), 32'd1);

    // Fairness: all requesting, eight transactions in strict rotation.
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) do_txn(k % 4);
    chk("fair_txn_count", 32'(txn_count), 32'd8);

    // Simultaneous requests: 0 first, then 1 in the IDLE cycle right after completion.
    do_reset();
    req_valid = 4'h3;
    do_txn(0);
    do_txn(1);
    chk("simul_txn_count", 32'(txn_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
